// File: rtl/fix2flt_pkg.sv
// Shared types and sizing helpers for the fixed-to-float converter.
package fix2flt_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS   = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } conv_state_t;

    function automatic int unsigned bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

    function automatic int unsigned float_width(input int unsigned exp_w, input int unsigned man_w);
        return 32'd1 + exp_w + man_w;
    endfunction

endpackage

// File: rtl/fix_to_float_conv_if.sv
// Start/done handshake bundle between the load/store path and the converter.
interface fix_to_float_conv_if #(
    parameter int unsigned W     = 16,
    parameter int unsigned FLT_W = 16
);
    logic             start;
    logic [W-1:0]     fix_in;
    logic             busy;
    logic             done;
    logic [FLT_W-1:0] flt_out;

    modport master (output start, fix_in, input busy, done, flt_out);
    modport slave  (input start, fix_in, output busy, done, flt_out);
endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even mantissa increment; carry flags mantissa overflow.
module fp_round_rne #(
    parameter int unsigned MAN_W = 10
) (
    input  logic [MAN_W-1:0] man,
    input  logic             guard,
    input  logic             sticky,
    input  logic             round_en,
    output logic [MAN_W-1:0] man_out,
    output logic             carry
);
    logic inc_c;

    assign inc_c = round_en & guard & (sticky | man[0]);
    assign {carry, man_out} = {1'b0, man} + (MAN_W + 1)'(inc_c);

endmodule

// File: rtl/fix_to_float_conv.sv
// Iterative signed fixed-point to packed float converter (one normalise shift per cycle).
module fix_to_float_conv
    import fix2flt_pkg::*;
#(
    parameter int unsigned INT_W    = 8,
    parameter int unsigned FRAC_W   = 8,
    parameter int unsigned EXP_W    = 5,
    parameter int unsigned MAN_W    = 10,
    parameter bit          ROUND_EN = 1'b1
) (
    input logic clk,
    input logic reset,
    fix_to_float_conv_if.slave bus
);
    localparam int unsigned W        = INT_W + FRAC_W;
    localparam int unsigned FLT_W    = float_width(EXP_W, MAN_W);
    localparam int unsigned BIAS_V   = bias(EXP_W);
    localparam int unsigned XW       = EXP_W + 1;
    localparam int unsigned G_IDX    = W - 2 - MAN_W;
    localparam int unsigned EXP_INIT = W - 1 - FRAC_W + BIAS_V;

    // Parameter sets that would need denormals, Inf or a wider mantissa are rejected.
    if (W - 1 <= MAN_W) begin : g_chk_man
        $fatal(1, "fix_to_float_conv: W-1 must exceed MAN_W");
    end
    if (int'(BIAS_V) - int'(FRAC_W) < 1) begin : g_chk_emin
        $fatal(1, "fix_to_float_conv: minimum exponent underflows");
    end
    if (W - FRAC_W + BIAS_V > (32'd1 << EXP_W) - 32'd2) begin : g_chk_emax
        $fatal(1, "fix_to_float_conv: maximum exponent overflows");
    end

    conv_state_t      state_q, state_d;
    logic [W-1:0]     fix_q, fix_d;
    logic [W-1:0]     mag_q, mag_d;
    logic [XW-1:0]    exp_q, exp_d;
    logic             sgn_q, sgn_d;
    logic [FLT_W-1:0] flt_q, flt_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             sticky_c;
    logic [MAN_W-1:0] man_rnd_c;
    logic             carry_c;
    logic [EXP_W-1:0] exp_out_c;

    if (G_IDX > 0) begin : g_sticky
        assign sticky_c = |mag_q[G_IDX-1:0];
    end else begin : g_no_sticky
        assign sticky_c = 1'b0;
    end

    fp_round_rne #(.MAN_W(MAN_W)) u_round (
        .man      (mag_q[W-2 -: MAN_W]),
        .guard    (mag_q[G_IDX]),
        .sticky   (sticky_c),
        .round_en (ROUND_EN),
        .man_out  (man_rnd_c),
        .carry    (carry_c)
    );

    // Top exponent bit is only headroom for the decrement; it never reaches the output.
    assign exp_out_c = exp_q[EXP_W-1:0] + EXP_W'(carry_c);

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        fix_d   = fix_q;
        mag_d   = mag_q;
        exp_d   = exp_q;
        sgn_d   = sgn_q;
        flt_d   = flt_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    fix_d   = bus.fix_in;
                    state_d = ABS;
                end
            end
            ABS: begin
                sgn_d = fix_q[W-1];
                mag_d = fix_q[W-1] ? W'(~fix_q + W'(1)) : fix_q;
                exp_d = XW'(EXP_INIT);
                if (fix_q == '0) begin
                    sgn_d   = 1'b0;
                    flt_d   = '0;
                    state_d = DONE;
                end else begin
                    state_d = NORM;
                end
            end
            NORM: begin
                if (!mag_q[W-1]) begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - XW'(1);
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                flt_d   = {sgn_q, exp_out_c, man_rnd_c};
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_q == DONE) && !bus.start;
        busy_d = (state_d == ABS) || (state_d == NORM) || (state_d == ROUND);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            fix_q   <= '0;
            mag_q   <= '0;
            exp_q   <= '0;
            sgn_q   <= 1'b0;
            flt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fix_q   <= fix_d;
            mag_q   <= mag_d;
            exp_q   <= exp_d;
            sgn_q   <= sgn_d;
            flt_q   <= flt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.flt_out = flt_q;

endmodule

// File: doc/fix_to_float_conv.md
Name: fix_to_float_conv

Overview:
- Parametrised, synthesizable successor to the Program 1 fixed-to-float converter.
- Converts a signed two's-complement fixed-point word (INT_W.FRAC_W) into a packed binary float {sign, EXP_W exponent, MAN_W mantissa}.
- Uses an iterative one-bit-per-cycle normaliser, with selectable round-to-nearest-even or truncation.
- Sits between the data-memory load path and the store path, under a start/done handshake.

Parameters:
- INT_W, 8: integer bits of the input, including the sign bit.
- FRAC_W, 8: fraction bits of the input; W = INT_W+FRAC_W.
- EXP_W, 5: exponent field width; BIAS = 2^(EXP_W-1)-1.
- MAN_W, 10: stored mantissa width, hidden one not stored.
- ROUND_EN, 1: 1 = round-to-nearest-even; 0 = truncate.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately.
- start  in  1  request; sampled only in IDLE or DONE.
- fix_in  in  W  two's-complement fixed input; sampled on the edge that accepts start.
- busy  out  1  high in ABS, NORM and ROUND.
- done  out  1  result valid; held high until the next accepted start.
- flt_out  out  1+EXP_W+MAN_W  packed float; stable while done=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE; done = 0, busy = 0, flt_out = 0; internal registers = 0.
  - Reset asserted mid-conversion aborts the conversion; no partial result is presented.
- States: IDLE, ABS, NORM, ROUND, DONE.
- IDLE / DONE:
  - start=1 captures fix_in and goes to ABS; done drops after that edge.
  - start=0 holds the current state.
- ABS:
  - sgn = fix_in[W-1]; mag = |fix_in| as W-bit unsigned.
  - Most-negative input gives mag = 2^(W-1); no trap is needed.
  - exp = W-1-FRAC_W+BIAS.
  - If mag == 0: flt_out = {sgn=0, all zeros}, go to DONE.
  - Otherwise go to NORM.
- NORM, one shift per cycle:
  - If mag[W-1] == 0: mag <<= 1, exp -= 1.
  - Else go to ROUND.
- ROUND:
  - man = mag[W-2 -: MAN_W]; G = mag[W-2-MAN_W]; S = OR of the lower bits (S = 0 if none).
  - ROUND_EN=1 and G & (S | man[0]): man += 1.
  - If the increment carries out, man = 0 and exp += 1.
  - flt_out = {sgn, exp, man}; go to DONE.
- Latency, counting from the edge that accepts start:
  - Nonzero input: done rises after edge k+4+lz, where lz = leading zeros of mag.
  - Defaults: 4 cycles for 0x8000, 19 cycles for 0x0001.
  - Zero input: done after edge k+2.
- start while busy=1 is ignored. fix_in changes after acceptance have no effect.
- Elaboration checks (fatal on failure):
  - W-1 > MAN_W.
  - Minimum biased exponent BIAS-FRAC_W >= 1, so no denormals arise.
  - Maximum biased exponent W-FRAC_W+BIAS <= 2^EXP_W-2, so no Inf arises.
- Exponent arithmetic uses EXP_W+1 bits internally; the top bit is discarded on output.

Decomposition:
- Package fix2flt_pkg:
  - state enum conv_state_t {IDLE, ABS, NORM, ROUND, DONE}.
  - function bias(EXP_W).
  - function float width.
- Sub-module fp_round_rne: combinational; {man, G, S, ROUND_EN} in, {man_out, carry} out. Instantiated once in ROUND.
- The top module holds the FSM, the magnitude/exponent registers and the output register.

Test Plan:
- Defaults, ROUND_EN=1:
  - fix_in=0x0100 (1.0) -> flt_out=0x3C00.
  - fix_in=0xFF00 (-1.0) -> flt_out=0xBC00.
  - done rises 4+7=11 cycles after start.
- Extremes:
  - fix_in=0x8000 -> flt_out=0xD800 after 4 cycles.
  - fix_in=0x0000 -> flt_out=0x0000 after 2 cycles.
  - fix_in=0x0001 -> flt_out=0x1C00 after 19 cycles.
- Rounding, ROUND_EN=1:
  - fix_in=0x0FFF -> 0x4C00 (carry into exponent).
  - fix_in=0x0801 -> 0x4800 (tie, even, no increment).
  - fix_in=0x0803 -> 0x4802 (tie, odd, round up).
- Truncation, ROUND_EN=0:
  - fix_in=0x0FFF -> 0x4BFF.
  - fix_in=0x0803 -> 0x4801.
- Handshake:
  - Pulse start with 0x0001, then pulse start with 0x0100 at cycle 5. The second pulse is ignored; the result is 0x1C00.
  - done stays high until the next start, then drops the following cycle.
- Reset mid-op: reset=0 during NORM -> done=0, busy=0, flt_out=0 immediately (asynchronous). A new start after release converts correctly.
